button_conditioner: RTL and testbench



---
 rtl/button_pkg.sv | 19 +
 rtl/button_channel.sv | 128 ++++++++++++
 rtl/button_conditioner.sv | 43 ++++
 tb/tb_button_conditioner.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared types and 50 MHz board defaults for the button conditioning path.
package button_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_REPEAT,
    ST_LOCKED
  } chan_state_e;

  localparam int unsigned DEF_NUM_BUTTONS         = 7;
  localparam int unsigned DEF_SYNC_STAGES         = 2;
  localparam int unsigned DEF_DEBOUNCE_CYCLES     = 500000;    // 10 ms
  localparam int unsigned DEF_REPEAT_DELAY_CYCLES = 25000000;  // 500 ms
  localparam int unsigned DEF_REPEAT_RATE_CYCLES  = 5000000;   // 100 ms
  localparam logic [6:0]  DEF_REPEAT_MASK         = 7'b0001111;
  localparam int unsigned DEF_ACTIVE_LOW_INPUTS   = 1;

endpackage

// File: rtl/button_channel.sv
// One button: synchroniser, debounce counter and press/repeat/release FSM.
module button_channel
  import button_pkg::*;
#(
  parameter int unsigned SYNC_STAGES         = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY_CYCLES = DEF_REPEAT_DELAY_CYCLES,
  parameter int unsigned REPEAT_RATE_CYCLES  = DEF_REPEAT_RATE_CYCLES,
  parameter bit          REPEAT_EN           = 1'b0,
  parameter bit          ACTIVE_LOW          = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic enable,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeating
);

  localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TMR_MAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                                    REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] DELAY_LAST = TMR_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [TMR_W-1:0] RATE_LAST  = TMR_W'(REPEAT_RATE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
  logic [TMR_W-1:0]       tmr_q, tmr_d;
  chan_state_e            state_q, state_d;
  logic pressed_q, pressed_d;
  logic press_pulse_q, press_pulse_d;
  logic release_pulse_q, release_pulse_d;
  logic repeating_q, repeating_d;
  logic level, mismatch, db_done, accept_press, accept_release;

  // Chain holds the "pressed = 1" polarity so reset means released.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], raw ^ ACTIVE_LOW};
    level  = sync_q[SYNC_STAGES-1];
  end

  always_comb begin
    mismatch       = (level != pressed_q);
    db_done        = mismatch && (db_cnt_q == DB_LAST);
    db_cnt_d       = (mismatch && !db_done) ? db_cnt_q + DB_W'(1) : '0;
    pressed_d      = pressed_q ^ db_done;
    accept_press   = db_done && !pressed_q;
    accept_release = db_done && pressed_q;
  end

  // Release is checked before the timer so it wins over a coincident repeat tick.
  always_comb begin
    state_d         = state_q;
    tmr_d           = tmr_q;
    press_pulse_d   = 1'b0;
    release_pulse_d = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
      tmr_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept_press) begin
            press_pulse_d = 1'b1;
            state_d       = REPEAT_EN ? ST_DELAY : ST_LOCKED;
            tmr_d         = '0;
          end
        end
        ST_DELAY, ST_REPEAT: begin
          if (accept_release) begin
            release_pulse_d = 1'b1;
            state_d         = ST_IDLE;
            tmr_d           = '0;
          end else if (tmr_q == ((state_q == ST_DELAY) ? DELAY_LAST : RATE_LAST)) begin
            press_pulse_d = 1'b1;
            state_d       = ST_REPEAT;
            tmr_d         = '0;
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end
        ST_LOCKED: begin
          if (accept_release) begin
            release_pulse_d = 1'b1;
            state_d         = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          tmr_d   = '0;
        end
      endcase
    end
    repeating_d = (state_d == ST_REPEAT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q          <= '0;
      db_cnt_q        <= '0;
      tmr_q           <= '0;
      state_q         <= ST_IDLE;
      pressed_q       <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      repeating_q     <= 1'b0;
    end else begin
      sync_q          <= sync_d;
      db_cnt_q        <= db_cnt_d;
      tmr_q           <= tmr_d;
      state_q         <= state_d;
      pressed_q       <= pressed_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
      repeating_q     <= repeating_d;
    end
  end

  assign pressed       = pressed_q;
  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;
  assign repeating     = repeating_q;

endmodule

// File: rtl/button_conditioner.sv
// N-channel push-button conditioner: debounced levels, press/release pulses, auto-repeat.
module button_conditioner
  import button_pkg::*;
#(
  parameter int unsigned            NUM_BUTTONS         = DEF_NUM_BUTTONS,
  parameter int unsigned            SYNC_STAGES         = DEF_SYNC_STAGES,
  parameter int unsigned            DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned            REPEAT_DELAY_CYCLES = DEF_REPEAT_DELAY_CYCLES,
  parameter int unsigned            REPEAT_RATE_CYCLES  = DEF_REPEAT_RATE_CYCLES,
  parameter logic [NUM_BUTTONS-1:0] REPEAT_MASK         = NUM_BUTTONS'(DEF_REPEAT_MASK),
  parameter int unsigned            ACTIVE_LOW_INPUTS   = DEF_ACTIVE_LOW_INPUTS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] raw_buttons,
  input  logic                   enable,
  output logic [NUM_BUTTONS-1:0] pressed,
  output logic [NUM_BUTTONS-1:0] press_pulse,
  output logic [NUM_BUTTONS-1:0] release_pulse,
  output logic [NUM_BUTTONS-1:0] repeating
);

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
    button_channel #(
      .SYNC_STAGES         (SYNC_STAGES),
      .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
      .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
      .REPEAT_RATE_CYCLES  (REPEAT_RATE_CYCLES),
      .REPEAT_EN           (REPEAT_MASK[i]),
      .ACTIVE_LOW          (ACTIVE_LOW_INPUTS != 0)
    ) u_chan (
      .clk           (clk),
      .rst_n         (reset),
      .raw           (raw_buttons[i]),
      .enable        (enable),
      .pressed       (pressed[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i]),
      .repeating     (repeating[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce/repeat timings.
module tb_button_conditioner;

  localparam int unsigned NB = 7;

  logic          clk;
  logic          reset;
  logic          enable;
  logic [NB-1:0] raw_buttons;
  logic [NB-1:0] pressed, press_pulse, release_pulse, repeating;
  logic [NB-1:0] e_pr, e_pp, e_rp, e_rep;
  int            n_cmp = 0;
  int            n_mis = 0;

  button_conditioner #(
    .NUM_BUTTONS         (7),
    .SYNC_STAGES         (2),
    .DEBOUNCE_CYCLES     (4),
    .REPEAT_DELAY_CYCLES (10),
    .REPEAT_RATE_CYCLES  (3),
    .REPEAT_MASK         (7'b0001111),
    .ACTIVE_LOW_INPUTS   (1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .raw_buttons   (raw_buttons),
    .enable        (enable),
    .pressed       (pressed),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .repeating     (repeating)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clr();
    e_pr  = '0;
    e_pp  = '0;
    e_rp  = '0;
    e_rep = '0;
  endtask

  task automatic chk(input string tag);
    logic [4*NB-1:0] obs, exp;
    obs = {pressed, press_pulse, release_pulse, repeating};
    exp = {e_pr, e_pp, e_rp, e_rep};
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed pr=%b pp=%b rp=%b rep=%b expected pr=%b pp=%b rp=%b rep=%b",
             tag, pressed, press_pulse, release_pulse, repeating, e_pr, e_pp, e_rp, e_rep);
    end
  endtask

  initial begin
    // Reset with random pins.
    reset       = 1'b0;
    enable      = 1'b1;
    raw_buttons = 7'($urandom);
    repeat (3) @(negedge clk);
    clr();
    chk("reset_state");
    raw_buttons = '1;
    @(negedge clk);
    reset = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      @(negedge clk);
      clr();
      chk($sformatf("post_reset_t%0d", t));
    end

    // Clean press/release on non-repeating channel 4.
    raw_buttons[4] = 1'b0;
    for (int t = 1; t <= 28; t++) begin
      @(negedge clk);
      clr();
      e_pr[4] = (t >= 6 && t < 26);
      e_pp[4] = (t == 6);
      e_rp[4] = (t == 26);
      chk($sformatf("norep_t%0d", t));
      if (t == 20) raw_buttons[4] = 1'b1;
    end

    // Bounce: two 3-cycle lows split by a 1-cycle high never get accepted.
    for (int c = 0; c <= 20; c++) begin
      raw_buttons[0] = !((c <= 2) || (c >= 4 && c <= 6));
      @(negedge clk);
      clr();
      chk($sformatf("bounce_t%0d", c + 1));
    end

    // Same glitch then steady low: accepted 6 cycles after the last edge (label 4).
    for (int c = 0; c <= 11; c++) begin
      raw_buttons[0] = !((c <= 2) || (c >= 4));
      @(negedge clk);
      clr();
      e_pr[0] = (c + 1 >= 10);
      e_pp[0] = (c + 1 == 10);
      chk($sformatf("glitch_press_t%0d", c + 1));
    end
    raw_buttons[0] = 1'b1;
    for (int t = 13; t <= 20; t++) begin
      @(negedge clk);
      clr();
      e_pr[0] = (t < 18);
      e_rp[0] = (t == 18);
      chk($sformatf("glitch_release_t%0d", t));
    end

    // Auto-repeat on channel 1; release lands on what would be a repeat tick (31).
    raw_buttons[1] = 1'b0;
    for (int t = 1; t <= 33; t++) begin
      @(negedge clk);
      clr();
      e_pr[1]  = (t >= 6 && t < 31);
      e_pp[1]  = (t == 6 || t == 16 || t == 19 || t == 22 || t == 25 || t == 28);
      e_rp[1]  = (t == 31);
      e_rep[1] = (t >= 16 && t < 31);
      chk($sformatf("repeat_t%0d", t));
      if (t == 25) raw_buttons[1] = 1'b1;
    end

    // Enable gating on channel 2.
    raw_buttons[2] = 1'b0;
    for (int t = 1; t <= 54; t++) begin
      @(negedge clk);
      clr();
      e_pr[2] = (t >= 6 && t < 36) || (t >= 46 && t < 53);
      e_pp[2] = (t == 6 || t == 46);
      e_rp[2] = (t == 53);
      chk($sformatf("enable_t%0d", t));
      if (t == 8)  enable = 1'b0;
      if (t == 20) enable = 1'b1;
      if (t == 30) raw_buttons[2] = 1'b1;
      if (t == 40) raw_buttons[2] = 1'b0;
      if (t == 47) raw_buttons[2] = 1'b1;
    end

    // Simultaneous press on 0 and 3, then reset mid-REPEAT while still held.
    raw_buttons[0] = 1'b0;
    raw_buttons[3] = 1'b0;
    for (int t = 1; t <= 18; t++) begin
      @(negedge clk);
      clr();
      e_pr[0]  = (t >= 6);
      e_pr[3]  = (t >= 6);
      e_pp[0]  = (t == 6 || t == 16);
      e_pp[3]  = (t == 6 || t == 16);
      e_rep[0] = (t >= 16);
      e_rep[3] = (t >= 16);
      chk($sformatf("simul_t%0d", t));
    end
    reset = 1'b0;
    #1;
    clr();
    chk("reset_async_clear");
    @(negedge clk);
    chk("reset_held");
    reset = 1'b1;
    for (int t = 20; t <= 27; t++) begin
      @(negedge clk);
      clr();
      e_pr[0] = (t >= 25);
      e_pr[3] = (t >= 25);
      e_pp[0] = (t == 25);
      e_pp[3] = (t == 25);
      chk($sformatf("after_reset_t%0d", t));
    end

    raw_buttons = '1;
    repeat (8) @(negedge clk);
    clr();
    chk("final_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
